// File: rtl/act_pipe.sv
// Multi-lane activation stage: ReLU / leaky / clip / saturating bypass with optional rounding,
// built as a 2-stage valid/ready pipeline that also keeps saturation statistics.
module act_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INT_WIDTH  = 2,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int          CLIP_VAL   = 'h4000,
    parameter int unsigned ROUND      = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*2*DATA_WIDTH-1:0]     in_data,
    input  logic [1:0]                        in_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*DATA_WIDTH-1:0]       out_data,
    output logic [LANES-1:0]                  out_sat,
    input  logic                              clr_stats,
    output logic [CNT_W-1:0]                  sat_count,
    output logic                              sat_sticky
);

    localparam int unsigned IN_W = 2 * DATA_WIDTH;
    localparam int unsigned F    = DATA_WIDTH - INT_WIDTH;
    localparam int unsigned YW   = IN_W + 1 - F;
    localparam int unsigned PW   = $clog2(LANES + 1);

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;

    localparam logic signed [IN_W:0]   RND_ADD = {{(IN_W-F+1){1'b0}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]  SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]  CLIP_L  = DATA_WIDTH'(CLIP_VAL);
    localparam logic [CNT_W+PW-1:0]    CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    logic                  r_s1_valid;
    logic [1:0]            r_s1_mode;
    logic [YW-1:0]         r_s1_y [LANES];
    logic [LANES-1:0]      r_s1_neg;
    logic                  r_out_valid;
    logic [LANES*DATA_WIDTH-1:0] r_out_data;
    logic [LANES-1:0]      r_out_sat;
    logic [CNT_W-1:0]      r_sat_count;
    logic                  r_sat_sticky;

    logic                  w_s1_load;
    logic                  w_s2_load;
    logic signed [IN_W:0]  w_x [LANES];
    logic signed [IN_W:0]  w_v [LANES];
    logic [YW-1:0]         w_y [LANES];
    logic [LANES-1:0]      w_ovf;
    logic [DATA_WIDTH-1:0] w_satv [LANES];
    logic [DATA_WIDTH-1:0] w_r [LANES];
    logic [LANES-1:0]      w_sat;
    logic [PW-1:0]         w_pop;
    logic [CNT_W+PW-1:0]   w_sum;
    logic [CNT_W-1:0]      w_cnt_next;

    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    // Stage 1: optional leak shift, rounding bias, then drop the F fraction bits.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_x[i] = {in_data[i*IN_W + IN_W - 1], in_data[i*IN_W +: IN_W]};
            if (in_mode == MODE_LEAKY && w_x[i][IN_W]) begin
                w_v[i] = w_x[i] >>> LEAK_SHIFT;
            end else begin
                w_v[i] = w_x[i];
            end
            if (ROUND != 0) begin
                w_v[i] = w_v[i] + RND_ADD;
            end
            w_y[i] = w_v[i][IN_W:F];
        end
    end

    // Stage 2: range saturation, then mode-specific zeroing / clipping of the result.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ovf[i] = !((&r_s1_y[i][YW-1:DATA_WIDTH-1]) || !(|r_s1_y[i][YW-1:DATA_WIDTH-1]));
            if (w_ovf[i]) begin
                w_satv[i] = r_s1_y[i][YW-1] ? SAT_MIN : SAT_MAX;
            end else begin
                w_satv[i] = r_s1_y[i][DATA_WIDTH-1:0];
            end
            w_r[i]   = w_satv[i];
            w_sat[i] = w_ovf[i];
            if (r_s1_mode == MODE_RELU || r_s1_mode == MODE_CLIP) begin
                if (r_s1_neg[i]) begin
                    w_r[i]   = '0;
                    w_sat[i] = 1'b0;
                end else if (r_s1_mode == MODE_CLIP && $signed(w_satv[i]) > $signed(CLIP_L)) begin
                    w_r[i] = CLIP_L;
                end
            end
            w_pop = w_pop + PW'(w_sat[i]);
        end
    end

    assign w_sum      = {{PW{1'b0}}, r_sat_count} + {{CNT_W{1'b0}}, w_pop};
    assign w_cnt_next = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_neg   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_y[i] <= '0;
            end
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
                r_s1_mode  <= in_mode;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_y[i]   <= w_y[i];
                    r_s1_neg[i] <= w_x[i][IN_W];
                end
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_sat   <= w_sat;
            for (int i = 0; i < LANES; i++) begin
                r_out_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_r[i];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A clear wins over a same-cycle increment; that beat is not counted.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_sat_count  <= '0;
            r_sat_sticky <= 1'b0;
        end else if (w_s2_load) begin
            r_sat_count  <= w_cnt_next;
            r_sat_sticky <= r_sat_sticky || (w_pop != '0);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;
    assign sat_count  = r_sat_count;
    assign sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_act_pipe.sv
// Directed bench for act_pipe: default instance plus a ROUND=1 / CNT_W=4 instance on shared inputs.
module tb_act_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_ready_r;
    logic [127:0] in_data;
    logic [1:0]   in_mode;
    logic         out_ready;
    logic         clr_stats;
    logic         out_valid;
    logic         out_valid_r;
    logic [63:0]  out_data;
    logic [63:0]  out_data_r;
    logic [3:0]   out_sat;
    logic [3:0]   out_sat_r;
    logic [15:0]  sat_count;
    logic [3:0]   sat_count_r;
    logic         sat_sticky;
    logic         sat_sticky_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    act_pipe u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .clr_stats  (clr_stats),
        .sat_count  (sat_count),
        .sat_sticky (sat_sticky)
    );

    act_pipe #(
        .ROUND (1),
        .CNT_W (4)
    ) u_dut_r (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_r),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid_r),
        .out_ready  (out_ready),
        .out_data   (out_data_r),
        .out_sat    (out_sat_r),
        .clr_stats  (clr_stats),
        .sat_count  (sat_count_r),
        .sat_sticky (sat_sticky_r)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk_in(input logic [31:0] x0, input logic [31:0] x1,
                                           input logic [31:0] x2, input logic [31:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [63:0] pk_out(input logic [15:0] r0, input logic [15:0] r1,
                                           input logic [15:0] r2, input logic [15:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // One isolated beat; returns at the negedge after the second edge, when the result is visible.
    task automatic apply(input logic [127:0] d, input logic [1:0] m, input logic clr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        @(negedge clk);
        check("lat_one_edge", {63'd0, out_valid}, 64'd0);
        in_valid  = 1'b0;
        in_mode   = 2'b10;
        clr_stats = clr;
        @(negedge clk);
        clr_stats = 1'b0;
        check("lat_two_edges", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rx;
        int fell;
        int ghost;
        logic [127:0] d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sat_count", {48'd0, sat_count}, 64'd0);
        check("rst_sticky", {63'd0, sat_sticky}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ReLU: 0.5, 2.0 (saturates), -0.5, most negative
        apply(pk_in(32'h0800_0000, 32'h2000_0000, 32'hF800_0000, 32'h8000_0000), 2'b00, 1'b0);
        check("relu_data", out_data, pk_out(16'h2000, 16'h7FFF, 16'h0000, 16'h0000));
        check("relu_sat", {60'd0, out_sat}, 64'b0010);
        check("relu_count", {48'd0, sat_count}, 64'd1);
        check("relu_sticky", {63'd0, sat_sticky}, 64'd1);

        apply(pk_in(32'h0800_0000, 32'h2000_0000, 32'hF800_0000, 32'h8000_0000), 2'b01, 1'b0);
        check("leaky_data", out_data, pk_out(16'h2000, 16'h7FFF, 16'hFC00, 16'hC000));
        check("leaky_sat", {60'd0, out_sat}, 64'b0010);
        check("leaky_count", {48'd0, sat_count}, 64'd2);

        apply(pk_in(32'h0800_0000, 32'h2000_0000, 32'hF800_0000, 32'h8000_0000), 2'b11, 1'b0);
        check("bypass_data", out_data, pk_out(16'h2000, 16'h7FFF, 16'hE000, 16'h8000));
        check("bypass_sat", {60'd0, out_sat}, 64'b1010);
        check("bypass_count", {48'd0, sat_count}, 64'd4);

        apply(pk_in(32'h1800_0000, 32'h0400_0000, 32'hF800_0000, 32'h2000_0000), 2'b10, 1'b0);
        check("clip_data", out_data, pk_out(16'h4000, 16'h1000, 16'h0000, 16'h4000));
        check("clip_sat", {60'd0, out_sat}, 64'b1000);
        check("clip_count", {48'd0, sat_count}, 64'd5);

        // Rounding: truncating vs round-half-up instance
        apply(pk_in(32'h0000_2000, 32'h1FFF_E000, 32'h0000_1FFF, 32'hFFFF_E000), 2'b11, 1'b0);
        check("trunc_data", out_data, pk_out(16'h0000, 16'h7FFF, 16'h0000, 16'hFFFF));
        check("trunc_sat", {60'd0, out_sat}, 64'b0000);
        check("trunc_count", {48'd0, sat_count}, 64'd5);
        check("round_data", out_data_r, pk_out(16'h0001, 16'h7FFF, 16'h0000, 16'h0000));
        check("round_sat", {60'd0, out_sat_r}, 64'b0010);
        check("round_count", {60'd0, sat_count_r}, 64'd6);

        // Clear coincident with a saturating stage-2 load
        d = pk_in(32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000);
        apply(d, 2'b11, 1'b1);
        check("clr_sat", {60'd0, out_sat}, 64'b1111);
        check("clr_count", {48'd0, sat_count}, 64'd0);
        check("clr_sticky", {63'd0, sat_sticky}, 64'd0);
        check("clr_count_r", {60'd0, sat_count_r}, 64'd0);

        // Counter ceiling on the 4-bit instance
        for (int k = 0; k < 4; k++) apply(d, 2'b11, 1'b0);
        check("ceil_count16", {48'd0, sat_count}, 64'd16);
        check("ceil_count4", {60'd0, sat_count_r}, 64'd15);
        apply(d, 2'b11, 1'b0);
        check("ceil_count16_b", {48'd0, sat_count}, 64'd20);
        check("ceil_count4_b", {60'd0, sat_count_r}, 64'd15);
        check("ceil_sticky4", {63'd0, sat_sticky_r}, 64'd1);

        // Backpressure: 6 back-to-back beats, out_ready low for loop cycles 3..6
        sent = 0;
        rx   = 0;
        fell = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 6);
            in_mode   = 2'b11;
            in_data   = pk_in(32'(sent*4 + 1) << 14, 32'(sent*4 + 2) << 14,
                              32'(sent*4 + 3) << 14, 32'(sent*4 + 4) << 14);
            #1;
            if (!in_ready) fell = 1;
            if (out_valid) begin
                check("bp_data", out_data, pk_out(16'(rx*4 + 1), 16'(rx*4 + 2),
                                                  16'(rx*4 + 3), 16'(rx*4 + 4)));
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) rx++;
        end
        check("bp_in_ready_fell", 64'(fell), 64'd1);
        check("bp_received", 64'(rx), 64'd6);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Reset with both stages occupied
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        @(negedge clk);
        in_data   = pk_in(32'h0400_0000, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_full", {62'd0, out_valid, in_ready}, 64'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_count", {48'd0, sat_count}, 64'd0);
        out_ready = 1'b1;
        ghost = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("mid_rst_ghost", 64'(ghost), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/act_pipe.md
Name: act_pipe

Overview:
Parametrised, multi-lane activation stage that replaces the single-lane ReLU after the neuron MAC. Each lane takes a double-width signed accumulator value and produces a DATA_WIDTH fixed-point activation. Four modes are supported: ReLU, leaky ReLU, clip and saturating bypass, with optional rounding. The datapath is a 2-stage valid/ready pipeline with backpressure and saturation statistics, and sits between the MAC array and the layer output buffer.

Parameters:
DATA_WIDTH, 16, output lane width; input lane width IN_W = 2*DATA_WIDTH.
INT_WIDTH, 2, integer bits of the output format (Q2.14 by default). The input format is Q(2*INT_WIDTH).(2*F), where F = DATA_WIDTH-INT_WIDTH.
LANES, 4, number of parallel lanes per beat.
LEAK_SHIFT, 3, leaky-ReLU negative slope is 2^-LEAK_SHIFT (arithmetic right shift).
CLIP_VAL, 16'h4000, clip-mode upper bound in output format (1.0); must be >= 0.
ROUND, 0, 1 = round-half-up on the F dropped bits; 0 = truncate.
CNT_W, 16, saturation counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], signed
in_mode  in  2  00 ReLU, 01 leaky, 10 clip, 11 bypass; sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed
out_sat  out  LANES  per-lane saturation flag, aligned with out_data
clr_stats  in  1  synchronous clear of the statistics
sat_count  out  CNT_W  running count of saturated lanes
sat_sticky  out  1  set when any lane has saturated since the last clear

Behaviour:
- Reset: `rst` is synchronous and active-high; `clk` is the only clock. While rst is high at a clk edge, every valid bit, out_data, out_sat, sat_count and sat_sticky go to 0. in_ready is 1 in the cycle after reset. Reset mid-stream discards all in-flight beats.
- Handshake: a transfer happens when valid && ready are both high at a clk edge. Pipeline flags are s1_valid (stage 1) and out_valid (stage 2).
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_load (combinational from out_ready; no registered skid)
  - Latency: exactly 2 clk edges from input transfer to out_valid when there is no stall.
  - Throughput: 1 beat per cycle.
  - No beat is lost or duplicated. out_data is held stable while out_valid && !out_ready.
- Stage 1 (registered per lane, in IN_W+1 bits signed, sign-extended x):
  - Leaky mode with x<0: v = x >>> LEAK_SHIFT. All other cases: v = x.
  - If ROUND=1: v = v + 2^(F-1).
  - y = v >>> F.
  - The mode is registered alongside the lane data.
- Stage 2 (registered per lane):
  - Signed saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat[i] = 1 if clamping occurred.
  - ReLU: r = (x<0) ? 0 : sat(y). Negative inputs never set out_sat. Rounding cannot make a negative input positive because the test uses the sign of x.
  - Leaky: r = sat(y).
  - Clip: r = (x<0) ? 0 : min(sat(y), CLIP_VAL). out_sat reflects only range saturation, not clipping.
  - Bypass: r = sat(y).
- Compatibility: mode 00 with ROUND=0 reproduces the legacy ReLU. With default widths, x>=0 gives 7FFF if |x[31:29], else x[29:14]; x<0 gives 0.
- Statistics:
  - On each s2_load, sat_count += popcount(new out_sat). The counter stops at 2^CNT_W-1 and does not wrap.
  - sat_sticky is set if the popcount is nonzero.
  - clr_stats has priority over a simultaneous increment: the result is 0, and that beat is not counted.
- in_mode is don't-care when in_valid=0. Invalid-to-valid transitions need no idle cycles.

Test Plan:
- Mode 00, ROUND=0, lane0 in 0x0800_0000 (0.5) -> out 0x2000 after 2 cycles, out_sat=0. Lane1 in 0x2000_0000 (2.0) -> 0x7FFF, out_sat[1]=1, sat_count=1, sat_sticky=1.
- Lane in 0xF800_0000 (-0.5): mode 00 -> 0x0000; mode 01 (LEAK_SHIFT=3) -> 0xFC00; mode 11 -> 0xE000. Lane in 0x8000_0000 in mode 11 -> 0x8000 with sat=1.
- Mode 10 with CLIP_VAL=0x4000: 0x1800_0000 (1.5) -> 0x4000, sat=0; 0x0400_0000 -> 0x1000.
- Rounding on 0x0000_2000 (bit 13): ROUND=0 -> 0x0000, ROUND=1 -> 0x0001. 0x1FFF_E000 with ROUND=1 -> 0x7FFF, sat=1 (carry into the overflow range).
- Backpressure: stream 6 beats back-to-back with out_ready low for cycles 3-6 -> in_ready falls once both stages are full. All 6 beats exit in order, unchanged, with no duplicates, and out_data is stable during the stall.
- Stats and reset:
  - clr_stats asserted in the same cycle as a saturating s2_load -> sat_count=0 the next cycle.
  - Force sat_count to max with CNT_W=4 -> stays at 15.
  - Assert rst with beats in both stages -> out_valid=0 the next cycle and no ghost beat appears afterwards.
